// File: rtl/lut_bin_loader.sv
// Frame-gated loader that rewrites all 256 binarization LUT entries on a vsync edge.
// Optional band (lo..hi) thresholding is enabled with `define LUT_BAND_EN.
module lut_bin_loader #(
  parameter logic [7:0] DEFAULT_THR    = 8'd128,
  parameter bit         VS_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync_in,
  input  logic       de_in,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_thr,
`ifdef LUT_BAND_EN
  input  logic [7:0] cfg_thr_hi,
  output logic [7:0] thr_active_hi,
`endif
  output logic       cfg_ready,
  output logic       lut_we,
  output logic [7:0] lut_a,
  output logic [7:0] lut_d,
  output logic       busy,
  output logic       load_done,
  output logic [7:0] thr_active,
  output logic       err_overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WRITE, DONE} state_t;

  localparam logic VS_INACTIVE = ~VS_ACTIVE_HIGH;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pend_q, pend_d;
  logic       vs_prev_q;
  logic       cfg_ready_q, cfg_ready_d;
  logic       lut_we_q, lut_we_d;
  logic [7:0] lut_a_q, lut_a_d;
  logic [7:0] lut_d_q, lut_d_d;
  logic       busy_q, busy_d;
  logic       load_done_q, load_done_d;
  logic [7:0] thr_active_q, thr_active_d;
  logic       err_q, err_d;
  logic       vs_edge;
  logic       accept;
  logic       hit;
`ifdef LUT_BAND_EN
  logic [7:0] pend_hi_q, pend_hi_d;
  logic [7:0] thr_active_hi_q, thr_active_hi_d;
`endif

  assign vs_edge = VS_ACTIVE_HIGH ? (v_sync_in & ~vs_prev_q) : (~v_sync_in & vs_prev_q);
  assign accept  = (state_q == IDLE) && cfg_valid && cfg_ready_q;

`ifdef LUT_BAND_EN
  assign hit = (cnt_q >= pend_q) && (cnt_q <= pend_hi_q);
`else
  assign hit = (cnt_q >= pend_q);
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_VS;
      cnt_q        <= 8'h00;
      pend_q       <= DEFAULT_THR;
      vs_prev_q    <= VS_INACTIVE;
      cfg_ready_q  <= 1'b0;
      lut_we_q     <= 1'b0;
      lut_a_q      <= 8'h00;
      lut_d_q      <= 8'h00;
      busy_q       <= 1'b1;
      load_done_q  <= 1'b0;
      thr_active_q <= 8'h00;
      err_q        <= 1'b0;
`ifdef LUT_BAND_EN
      pend_hi_q       <= 8'hFF;
      thr_active_hi_q <= 8'hFF;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      vs_prev_q    <= v_sync_in;
      cfg_ready_q  <= cfg_ready_d;
      lut_we_q     <= lut_we_d;
      lut_a_q      <= lut_a_d;
      lut_d_q      <= lut_d_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      thr_active_q <= thr_active_d;
      err_q        <= err_d;
`ifdef LUT_BAND_EN
      pend_hi_q       <= pend_hi_d;
      thr_active_hi_q <= thr_active_hi_d;
`endif
    end
  end

  // Next-state, address counter and pending-threshold latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
`ifdef LUT_BAND_EN
    pend_hi_d = pend_hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = cfg_thr;
`ifdef LUT_BAND_EN
          pend_hi_d = cfg_thr_hi;
`endif
          state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        cnt_d = 8'h00;
        if (vs_edge) state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 8'd1;
        // Leave after entry 255 so the counter never starts a second pass
        if (cnt_q == 8'hFF) begin
          cnt_d   = 8'h00;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = WAIT_VS;
    endcase
  end

  // Output next values, registered one cycle behind the state
  always_comb begin
    cfg_ready_d  = (state_q == IDLE) && !accept;
    busy_d       = (state_q != IDLE) || accept;
    lut_we_d     = (state_q == WRITE);
    lut_a_d      = (state_q == WRITE) ? cnt_q : 8'h00;
    lut_d_d      = ((state_q == WRITE) && hit) ? 8'hFF : 8'h00;
    load_done_d  = (state_q == DONE);
    thr_active_d = (state_q == DONE) ? pend_q : thr_active_q;
    err_d        = err_q | (lut_we_q & de_in);
`ifdef LUT_BAND_EN
    thr_active_hi_d = (state_q == DONE) ? pend_hi_q : thr_active_hi_q;
`endif
  end

  assign cfg_ready   = cfg_ready_q;
  assign lut_we      = lut_we_q;
  assign lut_a       = lut_a_q;
  assign lut_d       = lut_d_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign thr_active  = thr_active_q;
  assign err_overrun = err_q;
`ifdef LUT_BAND_EN
  assign thr_active_hi = thr_active_hi_q;
`endif

endmodule

// File: tb/tb_lut_bin_loader.sv
// Directed bench for lut_bin_loader; a shadow LUT captures the write bus for content checks.
module tb_lut_bin_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v_sync_in;
  logic       de_in;
  logic       cfg_valid;
  logic [7:0] cfg_thr;
  logic       cfg_ready;
  logic       lut_we;
  logic [7:0] lut_a;
  logic [7:0] lut_d;
  logic       busy;
  logic       load_done;
  logic [7:0] thr_active;
  logic       err_overrun;
`ifdef LUT_BAND_EN
  logic [7:0] cfg_thr_hi;
  logic [7:0] thr_active_hi;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic       mon_clr;
  logic [7:0] lut_mem [256];
  int         wr_cnt;
  int         done_cnt;

  always #5 clk = ~clk;

  lut_bin_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_sync_in   (v_sync_in),
    .de_in       (de_in),
    .cfg_valid   (cfg_valid),
    .cfg_thr     (cfg_thr),
`ifdef LUT_BAND_EN
    .cfg_thr_hi  (cfg_thr_hi),
    .thr_active_hi(thr_active_hi),
`endif
    .cfg_ready   (cfg_ready),
    .lut_we      (lut_we),
    .lut_a       (lut_a),
    .lut_d       (lut_d),
    .busy        (busy),
    .load_done   (load_done),
    .thr_active  (thr_active),
    .err_overrun (err_overrun)
  );

  // Shadow LUT: behaves like the synchronous write port of the real LUTs
  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      for (int i = 0; i < 256; i++) lut_mem[i] <= 8'h55;
    end else begin
      if (lut_we) begin
        lut_mem[lut_a] <= lut_d;
        wr_cnt         <= wr_cnt + 1;
      end
      if (load_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_entry(input int a, input logic [7:0] lo, input logic [7:0] hi);
    return (a >= int'(lo) && a <= int'(hi)) ? 8'hFF : 8'h00;
  endfunction

  task automatic send_cfg(input logic [7:0] lo);
    check("ready_before_cfg", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_thr   = lo;
    tick();
    cfg_valid = 1'b0;
    check("ready_after_accept", 32'(cfg_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    repeat (5) tick();
    check("no_write_before_vs", 32'(lut_we), 32'd0);
  endtask

  // Sync edge lands on edge N; writes visible after N+1..N+256, done after N+257
  task automatic load_and_check(input logic [7:0] lo, input logic [7:0] hi,
                                input int de_idx, input bit hold);
    int bad;
    mon_clr = 1'b1;
    tick();
    mon_clr   = 1'b0;
    v_sync_in = 1'b1;
    tick();
    check("we_low_at_edge", 32'(lut_we), 32'd0);
    if (hold) begin
      cfg_valid = 1'b1;
      cfg_thr   = 8'h33;
    end
    tick();
    check("first_we", 32'(lut_we), 32'd1);
    check("first_addr", 32'(lut_a), 32'd0);
    check("first_data", 32'(lut_d), 32'(exp_entry(0, lo, hi)));
    check("ready_in_write", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 255; i++) begin
      de_in = (i == de_idx);
      if (i == 50)  v_sync_in = 1'b0;
      if (i == 100) v_sync_in = 1'b1;
      if (i == 150) v_sync_in = 1'b0;
      tick();
    end
    de_in = 1'b0;
    check("last_we", 32'(lut_we), 32'd1);
    check("last_addr", 32'(lut_a), 32'hFF);
    check("last_data", 32'(lut_d), 32'(exp_entry(255, lo, hi)));
    tick();
    check("done_pulse", 32'(load_done), 32'd1);
    check("we_off_at_done", 32'(lut_we), 32'd0);
    check("thr_active", 32'(thr_active), 32'(lo));
`ifdef LUT_BAND_EN
    check("thr_active_hi", 32'(thr_active_hi), 32'(hi));
`endif
    tick();
    check("done_cleared", 32'(load_done), 32'd0);
    check("ready_after_done", 32'(cfg_ready), 32'd1);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("write_count", 32'(wr_cnt), 32'd256);
    check("done_count", 32'(done_cnt), 32'd1);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (lut_mem[a] !== exp_entry(a, lo, hi)) bad++;
    check("lut_contents_bad", 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    v_sync_in = 1'b0;
    de_in     = 1'b0;
    cfg_valid = 1'b0;
    cfg_thr   = 8'h00;
    mon_clr   = 1'b1;
`ifdef LUT_BAND_EN
    cfg_thr_hi = 8'hFF;
`endif
    repeat (3) tick();
    mon_clr = 1'b0;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(lut_we), 32'd0);
    check("rst_addr", 32'(lut_a), 32'd0);
    check("rst_data", 32'(lut_d), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_thr_active", 32'(thr_active), 32'd0);
    check("rst_err", 32'(err_overrun), 32'd0);
`ifdef LUT_BAND_EN
    check("rst_thr_active_hi", 32'(thr_active_hi), 32'hFF);
`endif
    rst_n = 1'b1;
    repeat (4) tick();
    check("wait_vs_busy", 32'(busy), 32'd1);
    check("wait_vs_no_we", 32'(lut_we), 32'd0);

    // Power-up DEFAULT_THR load
    load_and_check(8'd128, 8'hFF, -1, 1'b0);

    // Sync edge while idle must not start a load
    v_sync_in = 1'b1;
    repeat (3) tick();
    check("idle_vs_no_we", 32'(lut_we), 32'd0);
    check("idle_vs_not_busy", 32'(busy), 32'd0);
    v_sync_in = 1'b0;
    tick();

    send_cfg(8'h40);
    load_and_check(8'h40, 8'hFF, -1, 1'b0);
    send_cfg(8'h00);
    load_and_check(8'h00, 8'hFF, -1, 1'b0);
    send_cfg(8'hFF);
    load_and_check(8'hFF, 8'hFF, -1, 1'b0);

    // Overrun during write, plus cfg_valid held through the load
    check("err_before_overrun", 32'(err_overrun), 32'd0);
    send_cfg(8'h80);
    load_and_check(8'h80, 8'hFF, 37, 1'b1);
    check("err_set", 32'(err_overrun), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("held_cfg_accepted_ready", 32'(cfg_ready), 32'd0);
    check("held_cfg_accepted_busy", 32'(busy), 32'd1);
    load_and_check(8'h33, 8'hFF, -1, 1'b0);
    check("err_sticky", 32'(err_overrun), 32'd1);

    // Reset after 100 writes of a 0x10 load
    send_cfg(8'h10);
    v_sync_in = 1'b1;
    tick();
    repeat (100) tick();
    check("partial_addr", 32'(lut_a), 32'd99);
    rst_n     = 1'b0;
    v_sync_in = 1'b0;
    tick();
    check("mid_rst_we", 32'(lut_we), 32'd0);
    check("mid_rst_addr", 32'(lut_a), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_ready", 32'(cfg_ready), 32'd0);
    check("mid_rst_thr", 32'(thr_active), 32'd0);
    check("mid_rst_err", 32'(err_overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    load_and_check(8'd128, 8'hFF, -1, 1'b0);

`ifdef LUT_BAND_EN
    cfg_thr_hi = 8'h60;
    send_cfg(8'h20);
    load_and_check(8'h20, 8'h60, -1, 1'b0);
    cfg_thr_hi = 8'h10;
    send_cfg(8'h80);
    load_and_check(8'h80, 8'h10, -1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
